// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver with a 2-flop input synchronizer.
// Each bit is a 3-sample majority vote; a bad stop bit drops the byte.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rout,
    output logic       rout_en,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [15:0] LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] SMP_A = HALF - 16'd1;
    localparam logic [15:0] SMP_C = HALF + 16'd1;

    state_t      state, state_nxt;
    logic        rx_m, rx_s;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        smp_a, smp_a_nxt;
    logic        smp_b, smp_b_nxt;
    logic [7:0]  rout_nxt;
    logic        rout_en_nxt;
    logic        frame_err_nxt;
    logic        maj;
    logic        dec;
    logic        wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            smp_a     <= 1'b1;
            smp_b     <= 1'b1;
            rout      <= 8'h00;
            rout_en   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            smp_a     <= smp_a_nxt;
            smp_b     <= smp_b_nxt;
            rout      <= rout_nxt;
            rout_en   <= rout_en_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // The third vote is the live sample taken at the decision point.
    assign maj  = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign dec  = (cnt == SMP_C);
    assign wrap = (cnt == LAST);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        smp_a_nxt     = smp_a;
        smp_b_nxt     = smp_b;
        rout_nxt      = rout;
        rout_en_nxt   = 1'b0;
        frame_err_nxt = 1'b0;

        if (state == START || state == DATA || state == STOP) begin
            cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
            if (cnt == SMP_A) smp_a_nxt = rx_s;
            if (cnt == HALF)  smp_b_nxt = rx_s;
        end

        unique case (state)
            IDLE: begin
                cnt_nxt     = 16'd0;
                bit_idx_nxt = 3'd0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (dec && maj) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 16'd0;
                end else if (wrap) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                end
            end
            DATA: begin
                if (dec) shreg_nxt = {maj, shreg[7:1]};
                if (wrap) begin
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                if (dec) begin
                    cnt_nxt = 16'd0;
                    if (maj) begin
                        rout_nxt    = shreg;
                        rout_en_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_nxt = 16'd0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
            end
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed vectors for uart_rx_frame at 16 clks/bit.
// Cycle-indexed logs of the outputs are compared with hand-derived timing.
module tb_uart_rx_frame;

    localparam int CPB  = 16;
    localparam int LOGN = 8192;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rout;
    logic       rout_en;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int both   = 0;

    bit         en_log   [LOGN];
    bit         fe_log   [LOGN];
    bit         busy_log [LOGN];
    logic [7:0] rout_log [LOGN];

    typedef struct {
        logic [7:0] data;
        int         px;
        logic       stopv;
        int         hold;
        int         n_en;
        int         n_fe;
        logic [7:0] rout;
    } vec_t;

    vec_t vt [7];

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rout     (rout),
        .rout_en  (rout_en),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            en_log[cyc]   <= rout_en;
            fe_log[cyc]   <= frame_err;
            busy_log[cyc] <= rx_busy;
            rout_log[cyc] <= rout;
        end
        if (rout_en && frame_err) both <= both + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_en(input int a, input int b);
        int n = 0;
        for (int i = a; i < b && i < LOGN; i++) n += int'(en_log[i]);
        return n;
    endfunction

    function automatic int cnt_fe(input int a, input int b);
        int n = 0;
        for (int i = a; i < b && i < LOGN; i++) n += int'(fe_log[i]);
        return n;
    endfunction

    // px is the bit period in hundredths of a clock; glitch inverts one
    // cycle; stop_after >= 0 abandons the frame after that many cycles.
    task automatic drive_frame(input logic [7:0] b, input int px,
                               input logic stopv, input int glitch,
                               input int stop_after, output int t);
        int   n;
        int   j;
        logic v;
        t = cyc;
        n = (10 * px + 50) / 100;
        for (int c = 0; c < n; c++) begin
            if (stop_after >= 0 && c == stop_after) return;
            j = 0;
            while (j < 9 && ((j + 1) * px + 50) / 100 <= c) j++;
            if (j == 0)      v = 1'b0;
            else if (j == 9) v = stopv;
            else             v = b[j-1];
            if (c == glitch) v = ~v;
            rx = v;
            @(negedge clk);
        end
        rx = stopv;
    endtask

    initial begin
        int t, ta, tb, tc;

        vt[0] = '{8'h67, 1600, 1'b1,  0, 1, 0, 8'h67};
        vt[1] = '{8'hA5, 1600, 1'b0, 40, 0, 1, 8'h67};
        vt[2] = '{8'h31, 1600, 1'b1,  0, 1, 0, 8'h31};
        vt[3] = '{8'h55, 1536, 1'b1,  0, 1, 0, 8'h55};
        vt[4] = '{8'h55, 1664, 1'b1,  0, 1, 0, 8'h55};
        vt[5] = '{8'hFF, 1536, 1'b1,  0, 1, 0, 8'hFF};
        vt[6] = '{8'hFF, 1664, 1'b1,  0, 1, 0, 8'hFF};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rout", int'(rout), 0);
        chk("rst_en", int'(rout_en), 0);
        chk("rst_fe", int'(frame_err), 0);
        chk("rst_busy", int'(rx_busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            drive_frame(vt[i].data, vt[i].px, vt[i].stopv, -1, -1, t);
            if (vt[i].hold > 0) begin
                repeat (vt[i].hold * CPB) @(negedge clk);
                rx = 1'b1;
            end
            repeat (48) @(negedge clk);
            chk($sformatf("v%0d_en_cnt", i), cnt_en(t, cyc), vt[i].n_en);
            chk($sformatf("v%0d_fe_cnt", i), cnt_fe(t, cyc), vt[i].n_fe);
            chk($sformatf("v%0d_strobe_t", i),
                int'(vt[i].n_en > 0 ? en_log[t+157] : fe_log[t+157]), 1);
            chk($sformatf("v%0d_rout", i), int'(rout), int'(vt[i].rout));
            chk($sformatf("v%0d_busy_t0", i), int'(busy_log[t+2]), 0);
            chk($sformatf("v%0d_busy_t1", i), int'(busy_log[t+3]), 1);
            chk($sformatf("v%0d_busy_pre", i), int'(busy_log[t+156]), 1);
            chk($sformatf("v%0d_busy_end", i), int'(busy_log[t+157]),
                vt[i].n_en > 0 ? 0 : 1);
            chk($sformatf("v%0d_busy_idle", i), int'(rx_busy), 0);
        end

        // Short start glitch: false start decided at T0+10, idle at T0+11.
        t  = cyc;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("glitch_busy_dec", int'(busy_log[t+12]), 1);
        chk("glitch_busy_idle", int'(busy_log[t+13]), 0);
        chk("glitch_en_cnt", cnt_en(t, cyc), 0);
        chk("glitch_fe_cnt", cnt_fe(t, cyc), 0);
        chk("glitch_rout", int'(rout), 8'hFF);

        // One-cycle high pulse on the middle sample of D3.
        drive_frame(8'h00, 1600, 1'b1, 73, -1, t);
        repeat (48) @(negedge clk);
        chk("d3glitch_en_cnt", cnt_en(t, cyc), 1);
        chk("d3glitch_strobe_t", int'(en_log[t+157]), 1);
        chk("d3glitch_rout", int'(rout), 0);

        drive_frame(8'h77, 1600, 1'b1, -1, -1, ta);
        drive_frame(8'h30, 1600, 1'b1, -1, -1, tb);
        drive_frame(8'h0D, 1600, 1'b1, -1, -1, tc);
        repeat (48) @(negedge clk);
        chk("b2b_en_cnt", cnt_en(ta, cyc), 3);
        chk("b2b_fe_cnt", cnt_fe(ta, cyc), 0);
        chk("b2b_a_t", int'(en_log[ta+157]), 1);
        chk("b2b_a_byte", int'(rout_log[ta+157]), 8'h77);
        chk("b2b_b_t", int'(en_log[tb+157]), 1);
        chk("b2b_b_byte", int'(rout_log[tb+157]), 8'h30);
        chk("b2b_c_t", int'(en_log[tc+157]), 1);
        chk("b2b_c_byte", int'(rout_log[tc+157]), 8'h0D);

        // Reset in the middle of D4.
        drive_frame(8'h5A, 1600, 1'b1, -1, 88, t);
        chk("pre_rst_busy", int'(rx_busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rout", int'(rout), 0);
        chk("mid_rst_en", int'(rout_en), 0);
        chk("mid_rst_fe", int'(frame_err), 0);
        chk("mid_rst_busy", int'(rx_busy), 0);
        rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("post_rst_en_cnt", cnt_en(t, cyc), 0);
        chk("post_rst_fe_cnt", cnt_fe(t, cyc), 0);
        drive_frame(8'h03, 1600, 1'b1, -1, -1, t);
        repeat (48) @(negedge clk);
        chk("after_rst_en_cnt", cnt_en(t, cyc), 1);
        chk("after_rst_strobe_t", int'(en_log[t+157]), 1);
        chk("after_rst_rout", int'(rout), 8'h03);

        chk("en_fe_overlap", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
